// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - command FIFO and sequencer that drives a 16-bit ALU
//
// Accepts ALU commands over a valid/ready interface and queues them in a small
// FIFO. Each command is checked, driven onto the ALU inputs, and the result is
// captured after the ALU latency. The result is then returned over a second
// valid/ready interface.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready      command handshake; cmd_fn, cmd_a, cmd_b payload
//   alu_fn_sel/alu_data_a/b  registered ALU inputs, held between operations
//   alu_data_out/zero/carry  ALU result inputs, sampled after ALU_LAT cycles
//   rsp_valid/rsp_ready      response handshake; rsp_data, rsp_zero, rsp_carry,
//                            rsp_err payload
//   busy                     sequencer active or commands still queued
//   op_count                 completed responses, wraps at 256
module alu_cmd_sequencer #(
  parameter int DATA_W     = 16,
  parameter int FN_W       = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int ALU_LAT    = 1,
  parameter int FN_MAX     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [FN_W-1:0]   cmd_fn,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic [FN_W-1:0]   alu_fn_sel,
  output logic [DATA_W-1:0] alu_data_a,
  output logic [DATA_W-1:0] alu_data_b,
  input  logic [DATA_W-1:0] alu_data_out,
  input  logic              alu_zero_flag,
  input  logic              alu_carry_flag,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_zero,
  output logic              rsp_carry,
  output logic              rsp_err,
  output logic              busy,
  output logic [7:0]        op_count
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WAIT_W = $clog2(ALU_LAT + 1);
  localparam int ENT_W  = FN_W + 2 * DATA_W;

  localparam logic [FN_W-1:0] FN_MAX_L = FN_W'(FN_MAX);
  localparam logic [FN_W-1:0] FN_DIV   = FN_W'(3);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state, state_next;

  logic [ENT_W-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count, count_next;
  logic              fifo_empty, push, pop;

  logic [FN_W-1:0]   head_fn;
  logic [DATA_W-1:0] head_a, head_b;
  logic              head_bad;

  logic [FN_W-1:0]   hold_fn;
  logic [DATA_W-1:0] hold_a, hold_b;
  logic [WAIT_W-1:0] wait_cnt;

  assign fifo_empty = (count == '0);
  assign push       = cmd_valid && cmd_ready;
  assign pop        = (state == S_IDLE) && !fifo_empty;

  assign {head_fn, head_a, head_b} = fifo_mem[rd_ptr];
  // Illegal function codes and divide-by-zero never reach the ALU.
  assign head_bad = (head_fn > FN_MAX_L) || ((head_fn == FN_DIV) && (head_b == '0));

  assign rsp_valid = (state == S_RESP);
  assign busy      = (state != S_IDLE) || !fifo_empty;

  // ---------------- command FIFO ----------------
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {cmd_fn, cmd_a, cmd_b};
    end
  end

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  // cmd_ready is registered from the next count, so it never looks ahead to
  // a pop in the same cycle: a full FIFO refuses a push even while popping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      cmd_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count     <= count_next;
      cmd_ready <= (count_next != CNT_W'(FIFO_DEPTH));
    end
  end

  // ---------------- sequencer FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          state_next = head_bad ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: state_next = S_WAIT;
      S_WAIT: begin
        if (wait_cnt == '0) begin
          state_next = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_fn    <= '0;
      hold_a     <= '0;
      hold_b     <= '0;
      alu_fn_sel <= '0;
      alu_data_a <= '0;
      alu_data_b <= '0;
      wait_cnt   <= '0;
      rsp_data   <= '0;
      rsp_zero   <= 1'b0;
      rsp_carry  <= 1'b0;
      rsp_err    <= 1'b0;
      op_count   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            hold_fn <= head_fn;
            hold_a  <= head_a;
            hold_b  <= head_b;
            if (head_bad) begin
              rsp_data  <= '0;
              rsp_zero  <= 1'b0;
              rsp_carry <= 1'b0;
              rsp_err   <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          // The ALU inputs change only here, so they stay put during WAIT
          // and keep their last values between operations.
          alu_fn_sel <= hold_fn;
          alu_data_a <= hold_a;
          alu_data_b <= hold_b;
          wait_cnt   <= WAIT_W'(ALU_LAT);
        end
        S_WAIT: begin
          if (wait_cnt == '0) begin
            rsp_data  <= alu_data_out;
            rsp_zero  <= alu_zero_flag;
            rsp_carry <= alu_carry_flag;
            rsp_err   <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            op_count <= op_count + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - scoreboard bench for alu_cmd_sequencer with a behavioural ALU
module tb_alu_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [3:0]  cmd_fn;
  logic [15:0] cmd_a, cmd_b;
  logic [3:0]  alu_fn_sel;
  logic [15:0] alu_data_a, alu_data_b, alu_data_out;
  logic        alu_zero_flag, alu_carry_flag;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_zero, rsp_carry, rsp_err, busy;
  logic [7:0]  op_count;

  always #5 clk = ~clk;

  alu_cmd_sequencer dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_fn(cmd_fn), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_fn_sel(alu_fn_sel), .alu_data_a(alu_data_a), .alu_data_b(alu_data_b),
    .alu_data_out(alu_data_out), .alu_zero_flag(alu_zero_flag), .alu_carry_flag(alu_carry_flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_carry(rsp_carry), .rsp_err(rsp_err),
    .busy(busy), .op_count(op_count)
  );

  // ALU semantics: returns {carry, zero, data}
  function automatic logic [17:0] alu_ref(input logic [3:0] fn, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] w;
    w = '0;
    case (fn)
      4'd0: w = {1'b0, a} + {1'b0, b};
      4'd1: w = {1'b0, a} - {1'b0, b};
      4'd2: w = {1'b0, 16'(a * b)};
      4'd3: w = (b != 0) ? {1'b0, a / b} : 17'd0;
      4'd4: w = {1'b0, a & b};
      4'd5: w = {1'b0, a | b};
      4'd6: w = {1'b0, a ^ b};
      4'd7: w = {1'b0, ~a};
      4'd8: w = {1'b0, ~b};
      default: w = '0;
    endcase
    return {w[16], (w[15:0] == 16'd0), w[15:0]};
  endfunction

  // One-cycle registered ALU
  logic [17:0] alu_r;
  always @(posedge clk) alu_r <= alu_ref(alu_fn_sel, alu_data_a, alu_data_b);
  assign alu_data_out   = alu_r[15:0];
  assign alu_zero_flag  = alu_r[16];
  assign alu_carry_flag = alu_r[17];

  typedef struct {
    logic [15:0] data;
    logic        zero, carry, err;
    logic [3:0]  afn;
    logic [15:0] aa, ab;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          exp_ops = 0;
  int          rr_mode = 1;
  logic [3:0]  last_fn = '0;
  logic [15:0] last_a = '0, last_b = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [3:0] fn, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] d, input logic z, input logic c, input logic e);
    exp_t x;
    if (!e) begin
      last_fn = fn; last_a = a; last_b = b;
    end
    x.data = d; x.zero = z; x.carry = c; x.err = e;
    x.afn = last_fn; x.aa = last_a; x.ab = last_b;
    sb.push_back(x);
  endtask

  task automatic push_model(input logic [3:0] fn, input logic [15:0] a, input logic [15:0] b);
    logic [17:0] r;
    if (fn > 4'd8 || (fn == 4'd3 && b == 16'd0)) begin
      push_exp(fn, a, b, 16'd0, 1'b0, 1'b0, 1'b1);
    end else begin
      r = alu_ref(fn, a, b);
      push_exp(fn, a, b, r[15:0], r[16], r[17], 1'b0);
    end
  endtask

  // Present a command and return #1 after the edge that accepted it.
  task automatic drive(input logic [3:0] fn, input logic [15:0] a, input logic [15:0] b);
    int n = 0;
    @(negedge clk);
    cmd_fn = fn; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("cmd_accept_timeout", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic drain(input int limit);
    int n = 0;
    @(negedge clk);
    while ((sb.size() != 0 || rsp_valid || busy) && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (n >= limit) chk("drain_timeout", sb.size(), 32'd0);
  endtask

  // rsp_ready driver: 0 = hold off, 1 = always ready, 2 = random
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rr_mode)
        0:       rsp_ready = 1'b0;
        1:       rsp_ready = 1'b1;
        default: rsp_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Response monitor: every cycle a response is presented it must match the
  // scoreboard head; it is retired on the handshake.
  always @(negedge clk) begin
    if (rst && rsp_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
      end else begin
        mon_e = sb[0];
        chk("rsp_data",  {16'd0, rsp_data},   {16'd0, mon_e.data});
        chk("rsp_zero",  {31'd0, rsp_zero},   {31'd0, mon_e.zero});
        chk("rsp_carry", {31'd0, rsp_carry},  {31'd0, mon_e.carry});
        chk("rsp_err",   {31'd0, rsp_err},    {31'd0, mon_e.err});
        chk("alu_fn_sel", {28'd0, alu_fn_sel}, {28'd0, mon_e.afn});
        chk("alu_data_a", {16'd0, alu_data_a}, {16'd0, mon_e.aa});
        chk("alu_data_b", {16'd0, alu_data_b}, {16'd0, mon_e.ab});
        if (rsp_ready) begin
          void'(sb.pop_front());
          exp_ops++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int          acc, n, ops_before;
    logic        rdy;
    logic [3:0]  fn;
    logic [15:0] a, b;

    cmd_valid = 1'b0; cmd_fn = '0; cmd_a = '0; cmd_b = '0;
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_busy",      {31'd0, busy},      32'd0);
    chk("reset_op_count",  {24'd0, op_count},  32'd0);
    chk("reset_alu_fn",    {28'd0, alu_fn_sel}, 32'd0);
    chk("reset_alu_a",     {16'd0, alu_data_a}, 32'd0);
    chk("reset_rsp_data",  {16'd0, rsp_data},   32'd0);
    rst = 1'b1;
    #1 chk("ready_before_edge", {31'd0, cmd_ready}, 32'd0);
    @(posedge clk);
    #1 chk("ready_after_edge", {31'd0, cmd_ready}, 32'd1);

    // Add with latency measurement
    drive(4'd0, 16'h2001, 16'h0001);
    push_exp(4'd0, 16'h2001, 16'h0001, 16'h2002, 1'b0, 1'b0, 1'b0);
    n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (!rsp_valid && n < 20);
    chk("add_latency", n, 32'd4);
    drain(100);
    chk("op_count_after_add", {24'd0, op_count}, 32'd1);

    // Overflow, division, then the two reject cases
    drive(4'd0, 16'hFFFF, 16'h0001);
    push_exp(4'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0);
    drain(100);
    drive(4'd3, 16'h0009, 16'h0004);
    push_exp(4'd3, 16'h0009, 16'h0004, 16'h0002, 1'b0, 1'b0, 1'b0);
    drain(100);
    drive(4'd9, 16'h1234, 16'h5678);
    push_exp(4'd9, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b0, 1'b1);
    drain(100);
    drive(4'd3, 16'h0001, 16'h0000);
    push_exp(4'd3, 16'h0001, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
    drain(100);
    chk("op_count_after_directed", {24'd0, op_count}, 32'd5);

    // Backpressure: six back-to-back attempts, five fit
    rr_mode = 0;
    @(posedge clk);
    ops_before = exp_ops;
    acc = 0;
    rdy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      cmd_fn = 4'(i % 3); cmd_a = 16'($urandom); cmd_b = 16'($urandom) | 16'd1;
      cmd_valid = 1'b1;
      rdy = cmd_ready;
      @(posedge clk);
      if (rdy) begin
        push_model(cmd_fn, cmd_a, cmd_b);
        acc++;
      end
    end
    #1 cmd_valid = 1'b0;
    chk("bp_accepted", acc, 32'd5);
    chk("bp_sixth_ready", {31'd0, rdy}, 32'd0);
    repeat (8) @(negedge clk);
    chk("bp_rsp_held", {31'd0, rsp_valid}, 32'd1);
    chk("bp_cmd_ready_low", {31'd0, cmd_ready}, 32'd0);
    rr_mode = 1;
    drain(200);
    chk("bp_op_delta", exp_ops - ops_before, 32'd5);
    chk("bp_op_count", {24'd0, op_count}, 32'(exp_ops & 255));

    // Random commands with random response backpressure
    rr_mode = 2;
    for (int i = 0; i < 60; i++) begin
      fn = 4'($urandom_range(0, 11));
      a  = 16'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
      drive(fn, a, b);
      push_model(fn, a, b);
    end
    rr_mode = 1;
    drain(3000);
    chk("rand_op_count", {24'd0, op_count}, 32'(exp_ops & 255));

    // Reset while the sequencer sits in WAIT with two commands queued
    drive(4'd0, 16'h0001, 16'h0002);
    push_model(4'd0, 16'h0001, 16'h0002);
    drive(4'd1, 16'h0005, 16'h0003);
    push_model(4'd1, 16'h0005, 16'h0003);
    drive(4'd6, 16'h00FF, 16'h000F);
    push_model(4'd6, 16'h00FF, 16'h000F);
    rst = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid_rst_busy",      {31'd0, busy},      32'd0);
    chk("mid_rst_op_count",  {24'd0, op_count},  32'd0);
    chk("mid_rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("mid_rst_alu_fn",    {28'd0, alu_fn_sel}, 32'd0);
    sb.delete();
    exp_ops = 0;
    last_fn = '0; last_a = '0; last_b = '0;
    @(negedge clk);
    rst = 1'b1;
    #1 chk("post_rst_ready_before_edge", {31'd0, cmd_ready}, 32'd0);
    @(posedge clk);
    #1 chk("post_rst_ready_after_edge", {31'd0, cmd_ready}, 32'd1);
    repeat (20) @(negedge clk);
    chk("post_rst_busy",     {31'd0, busy},      32'd0);
    chk("post_rst_op_count", {24'd0, op_count},  32'd0);

    // Sequencer still works after the reset
    drive(4'd5, 16'hA000, 16'h0005);
    push_exp(4'd5, 16'hA000, 16'h0005, 16'hA005, 1'b0, 1'b0, 1'b0);
    drain(100);
    chk("final_op_count", {24'd0, op_count}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
